// File: rtl/convolution_ctrl.sv
// Frame sequencer for a 3x3 convolution datapath: flushes the line buffers, counts pixel
// positions, flags border pixels, waits out the datapath latency and latches the kernel select.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for i_frame_start; pending mode applied on exit
// S_FLUSH  | line buffers cleared for FLUSH_CYCLES cycles
// S_ACTIVE | accepting pixels and tracking (col,row)
// S_DRAIN  | waiting DRAIN_CYCLES cycles of datapath latency, then o_frame_done
module convolution_ctrl #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int FLUSH_CYCLES = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_frame_start,
    input  logic                          i_valid,
    input  logic [1:0]                    i_mode,
    input  logic                          i_mode_valid,
    output logic                          o_mode_ready,
    output logic [1:0]                    o_kernel_sel,
    output logic                          o_conv_clear,
    output logic                          o_conv_valid,
    output logic                          o_border,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
    output logic                          o_frame_done,
    output logic                          o_frame_err,
    output logic                          o_busy
);

    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int TMR_MAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W:0]   COL_EDGE   = (COL_W + 1)'(2);
    localparam logic [ROW_W:0]   ROW_EDGE   = (ROW_W + 1)'(2);
    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_ACTIVE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [TMR_W-1:0] tmr, tmr_next;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [1:0]       pend_mode;
    logic             accept;
    logic             start_err;
    logic             frame_end;
    logic             mode_hs;
    logic             at_edge;

    assign mode_hs = i_mode_valid && o_mode_ready;
    assign at_edge = ({1'b0, col_cnt} < COL_EDGE) || ({1'b0, row_cnt} < ROW_EDGE);

    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        accept     = 1'b0;
        start_err  = 1'b0;
        frame_end  = 1'b0;
        // A start pulse mid-frame wins over everything else, including a same-cycle pixel.
        if (i_frame_start && state != S_IDLE) begin
            start_err  = 1'b1;
            state_next = S_FLUSH;
            tmr_next   = FLUSH_LOAD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        state_next = S_FLUSH;
                        tmr_next   = FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (tmr == '0) begin
                        state_next = S_ACTIVE;
                    end else begin
                        tmr_next = tmr - TMR_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (i_valid) begin
                        accept = 1'b1;
                        if (col_cnt == COL_LAST && row_cnt == ROW_LAST) begin
                            state_next = S_DRAIN;
                            tmr_next   = DRAIN_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tmr == '0) begin
                        state_next = S_IDLE;
                        frame_end  = 1'b1;
                    end else begin
                        tmr_next = tmr - TMR_W'(1);
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmr          <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            o_col        <= '0;
            o_row        <= '0;
            o_conv_valid <= 1'b0;
            o_border     <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_kernel_sel <= 2'd0;
            pend_mode    <= 2'd0;
            o_mode_ready <= 1'b1;
        end else begin
            tmr          <= tmr_next;
            o_conv_valid <= accept;
            o_border     <= accept && at_edge;
            o_frame_done <= frame_end;
            o_frame_err  <= start_err;

            if (i_frame_start) begin
                col_cnt <= '0;
                row_cnt <= '0;
                o_col   <= '0;
                o_row   <= '0;
            end else if (accept) begin
                o_col <= col_cnt;
                o_row <= row_cnt;
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end

            // Kernel only changes on IDLE->FLUSH; a request landing that same cycle takes effect now.
            if (state == S_IDLE && i_frame_start) begin
                if (mode_hs) begin
                    o_kernel_sel <= i_mode;
                end else if (!o_mode_ready) begin
                    o_kernel_sel <= pend_mode;
                end
                o_mode_ready <= 1'b1;
            end else if (mode_hs) begin
                pend_mode    <= i_mode;
                o_mode_ready <= 1'b0;
            end
        end
    end

    assign o_conv_clear = (state == S_FLUSH);
    assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_convolution_ctrl.sv
// Scoreboard bench for convolution_ctrl: a frame-level reference model pushes expected
// per-cycle status and pixel positions; a monitor pops and compares after each edge.
module tb_convolution_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FC = 4;
    localparam int DC = 3;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          valid;
    logic [1:0]    mode;
    logic          mode_valid;
    logic          mode_ready;
    logic [1:0]    kernel_sel;
    logic          conv_clear;
    logic          conv_valid;
    logic          border;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          frame_done;
    logic          frame_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    convolution_ctrl #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .FLUSH_CYCLES(FC),
        .DRAIN_CYCLES(DC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frame_start(frame_start),
        .i_valid      (valid),
        .i_mode       (mode),
        .i_mode_valid (mode_valid),
        .o_mode_ready (mode_ready),
        .o_kernel_sel (kernel_sel),
        .o_conv_clear (conv_clear),
        .o_conv_valid (conv_valid),
        .o_border     (border),
        .o_col        (col),
        .o_row        (row),
        .o_frame_done (frame_done),
        .o_frame_err  (frame_err),
        .o_busy       (busy)
    );

    typedef struct {
        logic       busy;
        logic       clear;
        logic       cv;
        logic       border;
        logic       done;
        logic       err;
        logic       ready;
        logic [1:0] kernel;
        int         col;
        int         row;
    } stat_t;

    typedef struct {
        int   col;
        int   row;
        logic border;
    } pix_t;

    stat_t stat_q[$];
    pix_t  pix_q[$];

    // Reference model: frame phase, cycles left in the phase, linear pixel index.
    int m_phase   = 0;   // 0 idle, 1 flush, 2 active, 3 drain
    int m_left    = 0;
    int m_idx     = 0;
    int m_kernel  = 0;
    int m_pending = -1;
    int m_col     = 0;
    int m_row     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic fs, input logic v, input logic [1:0] md,
                              input logic mv, input logic r);
        stat_t s;
        pix_t  p;
        logic  hs;
        s.cv = 1'b0; s.border = 1'b0; s.done = 1'b0; s.err = 1'b0;
        if (r) begin
            m_phase = 0; m_left = 0; m_idx = 0; m_kernel = 0; m_pending = -1;
            m_col = 0; m_row = 0;
        end else begin
            hs = mv && (m_pending < 0);
            if (fs) begin
                if (m_phase == 0) begin
                    if (hs) m_kernel = int'(md);
                    else if (m_pending >= 0) m_kernel = m_pending;
                    m_pending = -1;
                end else begin
                    s.err = 1'b1;
                    if (hs) m_pending = int'(md);
                end
                m_phase = 1; m_left = FC; m_idx = 0; m_col = 0; m_row = 0;
            end else begin
                if (hs) m_pending = int'(md);
                case (m_phase)
                    1: begin
                        m_left--;
                        if (m_left == 0) m_phase = 2;
                    end
                    2: if (v) begin
                        m_col = m_idx % W;
                        m_row = m_idx / W;
                        s.cv = 1'b1;
                        s.border = (m_col < 2) || (m_row < 2);
                        p.col = m_col; p.row = m_row; p.border = s.border;
                        pix_q.push_back(p);
                        m_idx++;
                        if (m_idx == W * H) begin
                            m_phase = 3; m_left = DC; m_idx = 0;
                        end
                    end
                    3: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 0;
                            s.done = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        s.busy   = (m_phase != 0);
        s.clear  = (m_phase == 1);
        s.ready  = (m_pending < 0);
        s.kernel = 2'(m_kernel);
        s.col    = m_col;
        s.row    = m_row;
        stat_q.push_back(s);
    endtask

    // One clock: apply inputs, predict the post-edge outputs, then move to the next falling edge.
    task automatic cycle(input logic fs, input logic v, input logic [1:0] md,
                         input logic mv, input logic r);
        frame_start = fs;
        valid       = v;
        mode        = md;
        mode_valid  = mv;
        rst         = r;
        model_step(fs, v, md, mv, r);
        @(negedge clk);
    endtask

    task automatic finish_frame(input int gap);
        int n = 0;
        while (m_phase != 0 && n < 500) begin
            cycle(1'b0, (n % gap) == 0, 2'd0, 1'b0, 1'b0);
            n++;
        end
        if (m_phase != 0) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout actual=%0d expected=0", m_phase);
        end
    endtask

    task automatic run_until_idx(input int idx);
        int n = 0;
        while (!(m_phase == 2 && m_idx == idx) && n < 500) begin
            cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL reach_idx actual=%0d expected=%0d", m_idx, idx);
        end
    endtask

    initial begin : monitor
        stat_t s;
        pix_t  p;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                check("busy",       busy,       s.busy);
                check("conv_clear", conv_clear, s.clear);
                check("conv_valid", conv_valid, s.cv);
                check("border",     border,     s.border);
                check("frame_done", frame_done, s.done);
                check("frame_err",  frame_err,  s.err);
                check("mode_ready", mode_ready, s.ready);
                check("kernel_sel", kernel_sel, s.kernel);
                check("col",        col,        s.col);
                check("row",        row,        s.row);
                check("done_err_excl", frame_done & frame_err, 0);
            end
            if (conv_valid === 1'b1) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_pixel actual=(%0d,%0d) expected=none", col, row);
                end else begin
                    p = pix_q.pop_front();
                    check("pix_col",    col,    p.col);
                    check("pix_row",    row,    p.row);
                    check("pix_border", border, p.border);
                end
            end
        end
    end

    initial begin : stimulus
        frame_start = 1'b0;
        valid       = 1'b0;
        mode        = 2'd0;
        mode_valid  = 1'b0;
        rst         = 1'b1;

        repeat (3) cycle(1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        finish_frame(1);
        repeat (5) cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        finish_frame(3);

        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        run_until_idx(5);
        cycle(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        finish_frame(1);
        repeat (3) cycle(1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        finish_frame(1);

        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        run_until_idx(6);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        finish_frame(1);

        cycle(1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        run_until_idx(5);
        cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        finish_frame(2);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 499) == 0);
        end
        repeat (40) cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        check("pixels_outstanding", pix_q.size(), 0);
        check("status_outstanding", stat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
